// File: rtl/hs_deser_rx_if.sv
// ============================================================================
//  Module      : hs_deser_rx_if
//  Description : Serial-in / symbol-out bundle for the 10-bit symbol receiver.
//                The master side drives the bit strobe and the serial data.
//                The slave side (the deserializer) returns the symbols.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hs_deser_rx_if;
  logic       shift_enable;
  logic       serial_in;
  logic [9:0] parallel_out;
  logic       word_valid;
  logic       is_comma;
  logic       locked;

  modport master (
    output shift_enable,
    output serial_in,
    input  parallel_out,
    input  word_valid,
    input  is_comma,
    input  locked
  );

  modport slave (
    input  shift_enable,
    input  serial_in,
    output parallel_out,
    output word_valid,
    output is_comma,
    output locked
  );
endinterface

`default_nettype wire

// File: rtl/hs_deser_rx.sv
// ============================================================================
//  Module      : hs_deser_rx
//  Description : 10-bit serial symbol deserializer with K28.5 comma alignment.
//                It hunts for a comma to find the symbol boundary. Once
//                locked, it emits one symbol per 10 bit strobes. It realigns
//                after REALIGN_THRESH consecutive off-boundary commas.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_deser_rx #(
  parameter int REALIGN_THRESH = 2  // legal range 1..7
) (
  input  wire logic    clk,
  input  wire logic    n_rst,
  hs_deser_rx_if.slave bus
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [9:0] c_comma_neg = 10'b0011111010;  // K28.5, RD-
  localparam logic [9:0] c_comma_pos = 10'b1100000101;  // K28.5, RD+
  localparam logic [3:0] c_full      = 4'd10;
  localparam logic [3:0] c_last_bit  = 4'd9;
  localparam logic [3:0] c_thresh    = 4'(REALIGN_THRESH);

  logic [0:0] r_state;
  logic [9:0] r_sr;
  logic [3:0] r_fill;
  logic [3:0] r_bit_cnt;
  logic [2:0] r_realign_cnt;
  logic [9:0] r_parallel_out;
  logic       r_word_valid;
  logic       r_is_comma;

  logic [9:0] w_sr_next;
  logic       w_match;
  logic       w_full;
  logic [3:0] w_realign_inc;

  // Look one bit ahead: decisions are made on the window that this strobe
  // completes. The window counts as full on the strobe that delivers bit 10.
  always_comb begin
    w_sr_next     = {r_sr[8:0], bus.serial_in};
    w_match       = (w_sr_next == c_comma_neg) || (w_sr_next == c_comma_pos);
    w_full        = (r_fill >= c_last_bit);
    w_realign_inc = {1'b0, r_realign_cnt} + 4'd1;
  end

  // Shift window, boundary tracking and symbol output registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state        <= HUNT;
      r_sr           <= '0;
      r_fill         <= '0;
      r_bit_cnt      <= '0;
      r_realign_cnt  <= '0;
      r_parallel_out <= '0;
      r_word_valid   <= 1'b0;
      r_is_comma     <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (bus.shift_enable) begin
        r_sr <= w_sr_next;
        if (r_fill != c_full) begin
          r_fill <= r_fill + 4'd1;
        end
        case (r_state)
          HUNT: begin
            if (w_match && w_full) begin
              r_parallel_out <= w_sr_next;
              r_word_valid   <= 1'b1;
              r_is_comma     <= 1'b1;
              r_bit_cnt      <= '0;
              r_realign_cnt  <= '0;
              r_state        <= LOCKED;
            end
          end
          LOCKED: begin
            if (r_bit_cnt == c_last_bit) begin
              // On-boundary symbol: always emitted. Only a comma here
              // confirms the boundary and clears the slip evidence.
              r_parallel_out <= w_sr_next;
              r_word_valid   <= 1'b1;
              r_is_comma     <= w_match;
              r_bit_cnt      <= '0;
              if (w_match) begin
                r_realign_cnt <= '0;
              end
            end else if (w_match && (w_realign_inc == c_thresh)) begin
              // Enough off-boundary commas: adopt this edge as the boundary.
              r_parallel_out <= w_sr_next;
              r_word_valid   <= 1'b1;
              r_is_comma     <= 1'b1;
              r_bit_cnt      <= '0;
              r_realign_cnt  <= '0;
            end else begin
              if (w_match) begin
                r_realign_cnt <= w_realign_inc[2:0];
              end
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          default: begin
            r_state <= HUNT;
          end
        endcase
      end
    end
  end

  assign bus.parallel_out = r_parallel_out;
  assign bus.word_valid   = r_word_valid;
  assign bus.is_comma     = r_is_comma;
  assign bus.locked       = (r_state == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_hs_deser_rx.sv
// ============================================================================
//  Module      : tb_hs_deser_rx
//  Description : Scoreboard bench for hs_deser_rx. The driver pushes expected
//                symbols together with the strobe number that completes them.
//                A negedge monitor pops an entry on every word_valid pulse and
//                compares it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hs_deser_rx;

  typedef struct {
    logic [9:0] word;
    logic       comma;
    int         strobe;
  } exp_t;

  logic clk;
  logic n_rst;
  int   asserts;
  int   errors;
  int   strobe_cnt;
  exp_t exp_q[$];

  hs_deser_rx_if bus ();

  hs_deser_rx #(.REALIGN_THRESH(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    asserts++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every word_valid pulse must match the oldest expected symbol.
  always @(negedge clk) begin
    if (bus.word_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        asserts++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h at strobe %0d expected none",
                 bus.parallel_out, strobe_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word", int'(bus.parallel_out), int'(e.word));
        chk("is_comma", int'(bus.is_comma), int'(e.comma));
        chk("word_strobe", strobe_cnt, e.strobe);
        chk("locked_on_word", int'(bus.locked), 1);
      end
    end
  end

  task automatic push(input logic [9:0] w, input logic c, input int s);
    exp_t e;
    e.word   = w;
    e.comma  = c;
    e.strobe = s;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b, input int gap);
    bus.serial_in    = b;
    bus.shift_enable = 1'b1;
    @(posedge clk);
    strobe_cnt++;
    #1;
    bus.shift_enable = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sym(input logic [9:0] w, input int gap,
                          input logic expect_word, input logic c);
    if (expect_word) push(w, c, strobe_cnt + 10);
    for (int i = 9; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [9:0] v;
    asserts          = 0;
    errors           = 0;
    strobe_cnt       = 0;
    n_rst            = 1'b0;
    bus.shift_enable = 1'b0;
    bus.serial_in    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    chk("rst_parallel_out", int'(bus.parallel_out), 0);
    chk("rst_word_valid", int'(bus.word_valid), 0);
    chk("rst_is_comma", int'(bus.is_comma), 0);
    chk("rst_locked", int'(bus.locked), 0);

    // 1: lock on RD- comma, back-to-back strobes.
    send_sym(10'h0FA, 0, 1'b1, 1'b1);
    drain("t1_drained");
    chk("t1_locked", int'(bus.locked), 1);

    // 2: RD+ comma then a data symbol, 10 strobes apart.
    send_sym(10'h305, 0, 1'b1, 1'b1);
    send_sym(10'h2AA, 0, 1'b1, 1'b0);
    drain("t2_drained");
    chk("t2_hold_word", int'(bus.parallel_out), 10'h2AA);

    // 3: 3-bit slip, realign on the second off-boundary comma.
    do_reset();
    send_sym(10'h0FA, 0, 1'b1, 1'b1);
    push(10'h01F, 1'b0, strobe_cnt + 10);
    push(10'h11F, 1'b0, strobe_cnt + 20);
    push(10'h0FA, 1'b1, strobe_cnt + 23);
    push(10'h2AA, 1'b0, strobe_cnt + 33);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 0);
    send_sym(10'h0FA, 0, 1'b0, 1'b0);
    send_sym(10'h0FA, 0, 1'b0, 1'b0);
    send_sym(10'h2AA, 0, 1'b0, 1'b0);
    drain("t3_drained");
    chk("t3_locked", int'(bus.locked), 1);

    // 4: sparse zero strobes never lock; window holds between strobes.
    do_reset();
    for (int i = 0; i < 30; i++) send_bit(1'b0, 3);
    chk("t4_locked", int'(bus.locked), 0);
    drain("t4_no_word");
    send_sym(10'h0FA, 3, 1'b1, 1'b1);
    drain("t4_sparse_lock");

    // 5: mid-symbol reset discards the fragment and clears everything.
    do_reset();
    send_sym(10'h0FA, 0, 1'b1, 1'b1);
    v = 10'h2AA;
    for (int i = 9; i >= 5; i--) send_bit(v[i], 0);
    do_reset();
    chk("t5_parallel_out", int'(bus.parallel_out), 0);
    chk("t5_word_valid", int'(bus.word_valid), 0);
    chk("t5_is_comma", int'(bus.is_comma), 0);
    chk("t5_locked", int'(bus.locked), 0);
    v = 10'h0FA;
    for (int i = 9; i >= 1; i--) send_bit(v[i], 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_fragment_unlocked", int'(bus.locked), 0);
    push(10'h0FA, 1'b1, strobe_cnt + 1);
    send_bit(v[0], 0);
    drain("t5_drained");
    chk("t5_relocked", int'(bus.locked), 1);

    // 6: comma visible after only 9 strobes (stale zero MSB) is ignored.
    do_reset();
    v = 10'h0FA;
    for (int i = 8; i >= 0; i--) send_bit(v[i], 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_early_unlocked", int'(bus.locked), 0);
    drain("t6_no_word");
    send_sym(10'h0FA, 0, 1'b1, 1'b1);
    drain("t6_drained");
    chk("t6_locked", int'(bus.locked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
